// File: rtl/multi_key_debouncer.sv
// Purpose : debounces KEYS independent mechanical keys; emits level plus press/release/long-hold strobes.
// Latency : level and press/release strobe update GLITCH_CYCLES+2 edges after a pin change.
// Backpressure: none; strobes are single-cycle pulses that the consumer must sample every cycle.
//
// Ports:
//   clk_i          clock shared by all channels
//   rst_i          asynchronous active-high reset
//   key_i          raw asynchronous key pins (KEYS bits)
//   key_state_o    debounced level per channel, 1 = pressed
//   press_stb_o    one-cycle pulse when a press is accepted
//   release_stb_o  one-cycle pulse when a release is accepted
//   long_stb_o     one-cycle pulse after HOLD_CYCLES of continuous press
//   any_pressed_o  OR of key_state_o
module multi_key_debouncer #(
  parameter int CLK_FREQ_MHZ   = 20,
  parameter int GLITCH_TIME_NS = 1000,
  parameter int HOLD_TIME_US   = 500,
  parameter int KEYS           = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [KEYS-1:0] key_i,
  output logic [KEYS-1:0] key_state_o,
  output logic [KEYS-1:0] press_stb_o,
  output logic [KEYS-1:0] release_stb_o,
  output logic [KEYS-1:0] long_stb_o,
  output logic            any_pressed_o
);

  localparam int CLK_TIME_NS   = 1000 / CLK_FREQ_MHZ;
  localparam int GLITCH_RAW    = GLITCH_TIME_NS / CLK_TIME_NS;
  localparam int GLITCH_CYCLES = (GLITCH_RAW < 1) ? 1 : GLITCH_RAW;
  localparam int HOLD_CYCLES   = HOLD_TIME_US * CLK_FREQ_MHZ;
  localparam int CW            = $clog2(GLITCH_CYCLES + 1);

  // For active-low keys the idle pin level is 1, which is also the XOR mask
  // that turns a synchronised pin into a "pressed" bit.
  localparam logic ACT_LO = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] GLITCH_LAST = CW'(GLITCH_CYCLES - 1);

  logic [KEYS-1:0] sync1;
  logic [KEYS-1:0] sync2;
  logic [KEYS-1:0] pressed;
  logic [CW-1:0]   cnt [KEYS];

  assign pressed       = sync2 ^ {KEYS{ACT_LO}};
  assign any_pressed_o = |key_state_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1         <= {KEYS{ACT_LO}};
      sync2         <= {KEYS{ACT_LO}};
      key_state_o   <= '0;
      press_stb_o   <= '0;
      release_stb_o <= '0;
      for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
    end else begin
      sync1         <= key_i;
      sync2         <= sync1;
      press_stb_o   <= '0;
      release_stb_o <= '0;
      for (int k = 0; k < KEYS; k++) begin
        if (pressed[k] == key_state_o[k]) begin
          // Any agreeing sample restarts the stability window.
          cnt[k] <= '0;
        end else if (cnt[k] != GLITCH_LAST) begin
          cnt[k] <= cnt[k] + 1'b1;
        end else begin
          // GLITCH_CYCLES consecutive disagreeing samples: accept new level.
          cnt[k]           <= '0;
          key_state_o[k]   <= pressed[k];
          press_stb_o[k]   <= pressed[k];
          release_stb_o[k] <= ~pressed[k];
        end
      end
    end
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      localparam int HW = $clog2(HOLD_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
      localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

      logic [HW-1:0] hcnt [KEYS];

      // hcnt saturates at HOLD_MAX, so the HOLD_LAST -> HOLD_MAX step (and
      // hence the long strobe) happens at most once per press.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          long_stb_o <= '0;
          for (int k = 0; k < KEYS; k++) hcnt[k] <= '0;
        end else begin
          for (int k = 0; k < KEYS; k++) begin
            long_stb_o[k] <= key_state_o[k] && (hcnt[k] == HOLD_LAST);
            if (!key_state_o[k]) begin
              hcnt[k] <= '0;
            end else if (hcnt[k] != HOLD_MAX) begin
              hcnt[k] <= hcnt[k] + 1'b1;
            end
          end
        end
      end
    end else begin : g_no_hold
      assign long_stb_o = '0;
    end
  endgenerate

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench for multi_key_debouncer: 20 MHz, 10-cycle glitch filter,
// 40-cycle long hold, 4 active-low keys. Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns after a rising edge.
module tb_multi_key_debouncer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] key_i;
  logic [3:0] key_state_o;
  logic [3:0] press_stb_o;
  logic [3:0] release_stb_o;
  logic [3:0] long_stb_o;
  logic       any_pressed_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] acc_a;
  logic [3:0] acc_b;
  logic [3:0] acc_c;

  multi_key_debouncer #(
    .CLK_FREQ_MHZ  (20),
    .GLITCH_TIME_NS(500),
    .HOLD_TIME_US  (2),
    .KEYS          (4),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .key_i        (key_i),
    .key_state_o  (key_state_o),
    .press_stb_o  (press_stb_o),
    .release_stb_o(release_stb_o),
    .long_stb_o   (long_stb_o),
    .any_pressed_o(any_pressed_o)
  );

  always #25 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Advance n edges, OR-ing each strobe bus into the accumulators.
  task automatic tick_acc(input int n);
    acc_a = '0; acc_b = '0; acc_c = '0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      acc_a = acc_a | press_stb_o;
      acc_b = acc_b | release_stb_o;
      acc_c = acc_c | long_stb_o;
    end
  endtask

  initial begin
    rst_i = 1'b1;
    key_i = 4'hF;
    #60;
    chk("reset_state", key_state_o, 4'b0000);
    chk("reset_press", press_stb_o | release_stb_o | long_stb_o, 4'b0000);
    chk("reset_any", {3'b000, any_pressed_o}, 4'b0000);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    tick(5);
    chk("idle_state", key_state_o, 4'b0000);

    // 1. Press key 0: accepted exactly 12 edges after the pin change.
    key_i = 4'b1110;
    tick_acc(11);
    chk("t1_no_early_press", acc_a, 4'b0000);
    chk("t1_state_before", key_state_o, 4'b0000);
    tick(1);
    chk("t1_press_edge12", press_stb_o, 4'b0001);
    chk("t1_state_edge12", key_state_o, 4'b0001);
    chk("t1_any", {3'b000, any_pressed_o}, 4'b0001);
    tick(1);
    chk("t1_press_one_cycle", press_stb_o, 4'b0000);

    // 3. Keep key 0 held: long strobe exactly 40 edges after the press strobe.
    tick_acc(38);
    chk("t3_no_early_long", acc_c, 4'b0000);
    tick(1);
    chk("t3_long_edge40", long_stb_o, 4'b0001);
    tick_acc(25);
    chk("t3_no_second_long", acc_c, 4'b0000);
    chk("t3_still_pressed", key_state_o, 4'b0001);

    // 2. Key 1 bounces low for 9 cycles, five times: never accepted.
    acc_a = '0; acc_b = '0;
    for (int r = 0; r < 5; r++) begin
      key_i[1] = 1'b0;
      for (int i = 0; i < 9; i++) begin
        tick(1);
        acc_a = acc_a | press_stb_o | release_stb_o;
        acc_b = acc_b | key_state_o;
      end
      key_i[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick(1);
        acc_a = acc_a | press_stb_o | release_stb_o;
        acc_b = acc_b | key_state_o;
      end
    end
    tick(4);
    chk("t2_no_strobes", acc_a, 4'b0000);
    chk("t2_state_k1", acc_b & 4'b0010, 4'b0000);

    // 4. Release key 0: release strobe 12 edges after the pin change.
    key_i[0] = 1'b1;
    tick_acc(11);
    chk("t4_no_early_release", acc_b, 4'b0000);
    tick(1);
    chk("t4_release_edge12", release_stb_o, 4'b0001);
    chk("t4_state_low", key_state_o, 4'b0000);
    chk("t4_no_press_with_release", press_stb_o, 4'b0000);
    tick(1);
    chk("t4_release_one_cycle", release_stb_o, 4'b0000);

    // 4b. Press then release so key_state is high for only 30 cycles: no long.
    key_i[0] = 1'b0;
    tick(12);
    chk("t4b_press", press_stb_o, 4'b0001);
    tick_acc(18);
    key_i[0] = 1'b1;
    acc_c = acc_c | long_stb_o;
    begin
      logic [3:0] lc;
      lc = acc_c;
      tick_acc(12);
      chk("t4b_release_at_30", release_stb_o, 4'b0001);
      lc = lc | acc_c;
      tick_acc(50);
      chk("t4b_no_long", lc | acc_c, 4'b0000);
    end

    // 5. Keys 2 and 3 fall together, then only key 2 is released.
    key_i = 4'b0011;
    tick(12);
    chk("t5_dual_press", press_stb_o, 4'b1100);
    chk("t5_any", {3'b000, any_pressed_o}, 4'b0001);
    key_i = 4'b0111;
    tick(12);
    chk("t5_release_k2", release_stb_o, 4'b0100);
    chk("t5_state_k3_only", key_state_o, 4'b1000);
    chk("t5_any_still", {3'b000, any_pressed_o}, 4'b0001);
    key_i = 4'b1111;
    tick(12);
    chk("t5_all_released", key_state_o, 4'b0000);

    // 6. Reset during a count while another key is already pressed.
    key_i = 4'b1101;
    tick(12);
    chk("t6_k1_pressed", key_state_o, 4'b0010);
    key_i = 4'b1100;
    tick(6);
    rst_i = 1'b1;
    #1;
    chk("t6_reset_state", key_state_o, 4'b0000);
    chk("t6_reset_any", {3'b000, any_pressed_o}, 4'b0000);
    tick(2);
    rst_i = 1'b0;
    tick_acc(11);
    chk("t6_no_early_press", acc_a, 4'b0000);
    tick(1);
    chk("t6_press_after_reset", press_stb_o, 4'b0011);
    chk("t6_state_after_reset", key_state_o, 4'b0011);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
